seg7_capture: RTL and testbench

- Reverse path of the hex-to-7-segment decoder. Snoops the multiplexed 4-digit display bus: active-low anodes plus active-low segments a..g.
- Reconstructs the 4-bit hex code shown on each digit and publishes a 16-bit word once per complete refresh frame.
- Sits beside the display driver as a self-check and readback monitor for the message-scrolling designs.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 38 +++
 rtl/seg7_capture.sv | 148 ++++++++++++++
 tb/tb_seg7_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the team hex segment table (active low,
// bit6 = a .. bit0 = g), the blank pattern and the capture FSM encodings.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b1110010;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PUBLISH = 1'b1;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex segment table: pattern -> nibble, with
// flags for the all-off pattern and for patterns outside the table.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    blank  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Display-bus snooper: rebuilds the four hex digits from the multiplexed
// anode/segment bus and publishes them once per frame. Optional idle
// watchdog enabled by defining SEG7_CAPTURE_TIMEOUT_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  led,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic [3:0]  blank,
  output logic        stale,
  output logic [0:0]  fsm_state
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [3:0]  an_s1, an_s2, an_prev;
  logic [6:0]  led_s1, led_s2, led_prev;
  logic [7:0]  stable_cnt;
  logic [3:0]  mask, mask_next;
  logic [15:0] hold_nib;
  logic [3:0]  hold_err, hold_blank;
  logic [0:0]  state, state_next;
  logic [3:0]  dec_nib;
  logic        dec_err, dec_blank;
  logic        an_legal, same, capture, timeout_hit;
  logic [3:0]  sel;

  seg7_pattern_decode u_decode (
    .pattern (led_s2),
    .nibble  (dec_nib),
    .err     (dec_err),
    .blank   (dec_blank)
  );

  // Exactly one anode low selects a digit; blanking or overlap samples nothing.
  assign sel      = ~an_s2;
  assign an_legal = $onehot(sel);
  assign same     = ({an_s2, led_s2} == {an_prev, led_prev});
  // Fires once per dwell: the counter saturates and only a change re-arms it.
  assign capture  = an_legal && same && ((stable_cnt + 8'd1) == STABLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_s1      <= 4'hF;
      an_s2      <= 4'hF;
      an_prev    <= 4'hF;
      led_s1     <= SEG_BLANK;
      led_s2     <= SEG_BLANK;
      led_prev   <= SEG_BLANK;
      stable_cnt <= 8'd0;
    end else begin
      an_s1    <= an;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      led_s1   <= led;
      led_s2   <= led_s1;
      led_prev <= led_s2;
      if (!an_legal || !same)
        stable_cnt <= 8'd0;
      else if (stable_cnt != STABLE)
        stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // The publish clear comes first so a capture in that cycle survives it.
  always_comb begin
    mask_next = mask;
    if (state == ST_PUBLISH || timeout_hit)
      mask_next = 4'b0000;
    if (capture)
      mask_next = mask_next | sel;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: if (mask == 4'b1111) state_next = ST_PUBLISH;
      default:    state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_COLLECT;
      mask        <= 4'b0000;
      hold_nib    <= 16'h0000;
      hold_err    <= 4'b0000;
      hold_blank  <= 4'b0000;
      value       <= 16'h0000;
      digit_err   <= 4'b0000;
      blank       <= 4'b0000;
      frame_valid <= 1'b0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      for (int i = 0; i < 4; i++) begin
        if (capture && sel[i]) begin
          hold_nib[i*4 +: 4] <= dec_nib;
          hold_err[i]        <= dec_err;
          hold_blank[i]      <= dec_blank;
        end
      end
      frame_valid <= (state == ST_PUBLISH);
      if (state == ST_PUBLISH) begin
        value     <= hold_nib;
        digit_err <= hold_err;
        blank     <= hold_blank;
      end
    end
  end

  assign fsm_state = state;

`ifdef SEG7_CAPTURE_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT = 20'(TIMEOUT_CYCLES);
  logic [19:0] idle_cnt;

  assign timeout_hit = !capture && (idle_cnt == TIMEOUT - 20'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= 20'd0;
      stale    <= 1'b0;
    end else begin
      if (capture)
        idle_cnt <= 20'd0;
      else if (idle_cnt != TIMEOUT)
        idle_cnt <= idle_cnt + 20'd1;
      if (state == ST_PUBLISH)
        stale <= 1'b0;
      else if (timeout_hit)
        stale <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign stale       = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: drives display scans, queues expected
// frames and checks each frame_valid against the queue head.
module tb_seg7_capture;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  led;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic [3:0]  blank;
  logic        stale;
  logic [0:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .led         (led),
    .value       (value),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
    .blank       (blank),
    .stale       (stale),
    .fsm_state   (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One anode dwell; the first `glitch` cycles carry a random unsettled pattern.
  task automatic show(input int idx, input logic [6:0] pat, input int dwell, input int glitch);
    an  = ~(4'b0001 << idx);
    led = (glitch > 0) ? 7'($urandom_range(0, 127)) : pat;
    tick(glitch);
    led = pat;
    tick(dwell - glitch);
  endtask

  task automatic scan4(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                       input logic [6:0] p0, input int glitch);
    show(3, p3, 10, glitch);
    show(2, p2, 10, glitch);
    show(1, p1, 10, glitch);
    show(0, p0, 10, glitch);
    an = 4'hF;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every published frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_frame observed value=%h expected no frame", value);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("frame_value", value, mon_exp[23:8]);
        check("frame_err", digit_err, mon_exp[7:4]);
        check("frame_blank", blank, mon_exp[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    an    = 4'hF;
    led   = SEG_BLANK;
    tick(3);
    check("rst_value", value, 16'h0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_err", digit_err, 0);
    check("rst_blank", blank, 0);
    check("rst_stale", stale, 0);
    check("rst_state", fsm_state, ST_COLLECT);
    reset = 1'b1;
    tick(2);

    // Clean scan of 1234
    exp_q.push_back({16'h1234, 4'b0000, 4'b0000});
    scan4(SEG_1, SEG_2, SEG_3, SEG_4, 0);
    wait_drain("drain_1234", 40);
    tick(20);
    check("hold_1234", value, 16'h1234);

    // Unsettled first two cycles of each dwell
    exp_q.push_back({16'hA0F8, 4'b0000, 4'b0000});
    scan4(SEG_A, SEG_0, SEG_F, SEG_8, 2);
    wait_drain("drain_a0f8", 40);

    // Blank on digit 3, illegal pattern on digit 1
    exp_q.push_back({16'h0507, 4'b0010, 4'b1000});
    scan4(SEG_BLANK, SEG_5, 7'b1111110, SEG_7, 0);
    wait_drain("drain_errblank", 40);

    // Digit 3 shown twice before the frame completes: last capture wins
    exp_q.push_back({16'hC2DE, 4'b0000, 4'b0000});
    show(3, SEG_1, 10, 0);
    show(2, SEG_2, 10, 0);
    show(3, SEG_C, 10, 0);
    show(1, SEG_D, 10, 0);
    show(0, SEG_E, 10, 0);
    an = 4'hF;
    wait_drain("drain_repeat", 40);

    // Illegal anode patterns must not capture anything
    an  = 4'b0011;
    led = SEG_1;
    tick(20);
    an = 4'hF;
    tick(20);
    check("hold_after_bad_an", value, 16'hC2DE);

    // Reset in mid-frame discards the partial captures
    show(3, SEG_5, 10, 0);
    show(2, SEG_6, 10, 0);
    show(1, SEG_7, 10, 0);
    reset = 1'b0;
    tick(2);
    check("midrst_value", value, 16'h0);
    check("midrst_err", digit_err, 0);
    check("midrst_blank", blank, 0);
    check("midrst_frame_valid", frame_valid, 0);
    reset = 1'b1;
    an    = 4'hF;
    tick(2);
    show(0, SEG_8, 10, 0);
    an = 4'hF;
    tick(20);
    exp_q.push_back({16'h5678, 4'b0000, 4'b0000});
    scan4(SEG_5, SEG_6, SEG_7, SEG_8, 0);
    wait_drain("drain_5678", 40);

`ifdef SEG7_CAPTURE_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (stale !== 1'b1 && waited < 100) begin
        tick(1);
        waited++;
      end
      check("stale_set", stale, 1);
      exp_q.push_back({16'h9999, 4'b0000, 4'b0000});
      scan4(SEG_9, SEG_9, SEG_9, SEG_9, 0);
      wait_drain("drain_9999", 40);
      check("stale_cleared", stale, 0);
    end
`else
    tick(60);
    check("stale_tied_low", stale, 0);
`endif

    check("leftover_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
